// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, data-memory freeze and
// branch flush handling, plus saturating stall/flush event counters.
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_Rt_i,
    input  logic [4:0]  IFID_Rs_i,
    input  logic [4:0]  IFID_Rt_i,
    input  logic        branch_taken_i,
    input  logic        dmem_stall_i,
    input  logic        clear_i,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IDEXWrite_o,
    output logic        bubble_o,
    output logic        IFIDFlush_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_LDUSE  = 2'b01;
    localparam logic [1:0] ST_FREEZE = 2'b10;

    logic        load_use_s;
    logic        flush_pend_r;
    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    assign load_use_s = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                        ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

    // Pipeline enables: held inactive while reset is asserted so nothing advances.
    always_comb begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        IDEXWrite_o = 1'b0;
        bubble_o    = 1'b0;
        IFIDFlush_o = 1'b0;
        if (!rst_i) begin
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            IDEXWrite_o = 1'b0;
            bubble_o    = 1'b0;
            IFIDFlush_o = 1'b0;
        end else begin
            PCWrite_o   = !(dmem_stall_i || load_use_s);
            IFIDWrite_o = !(dmem_stall_i || load_use_s);
            IDEXWrite_o = !dmem_stall_i;
            bubble_o    = load_use_s && !dmem_stall_i;
            IFIDFlush_o = !dmem_stall_i && !load_use_s &&
                          (branch_taken_i || flush_pend_r);
        end
    end

    // Next-state selection; any current state (including 2'b11) follows the inputs.
    always_comb begin
        state_nxt_s = ST_RUN;
        if (dmem_stall_i) begin
            state_nxt_s = ST_FREEZE;
        end else if (load_use_s) begin
            state_nxt_s = ST_LDUSE;
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    // State and deferred-flush tracking; a branch seen during a freeze is replayed afterwards.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= ST_RUN;
            flush_pend_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (branch_taken_i && dmem_stall_i) begin
                flush_pend_r <= 1'b1;
            end else if (IFIDFlush_o) begin
                flush_pend_r <= 1'b0;
            end else begin
                flush_pend_r <= flush_pend_r;
            end
        end
    end

    // Saturating event counters; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else if (clear_i) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (!PCWrite_o) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (IFIDFlush_o) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign state_o     = state_r;
    assign stall_cnt_o = stall_cnt_r;
    assign flush_cnt_o = flush_cnt_r;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i (rising edge) and rst_i (active-low, asynchronous).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk_i  in  1  pipeline clock
- rst_i  in  1  asynchronous active-low reset
- IDEX_MemRead_i  in  1  load instruction currently in EX
- IDEX_Rt_i  in  5  destination register of that load
- IFID_Rs_i  in  5  rs field of the instruction in ID
- IFID_Rt_i  in  5  rt field of the instruction in ID
- branch_taken_i  in  1  branch/jump resolved taken in ID
- dmem_stall_i  in  1  data memory busy; freeze the whole pipe
- clear_i  in  1  synchronous counter clear
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID register load enable
- IDEXWrite_o  out  1  ID/EX register load enable
- bubble_o  out  1  zero all control inputs into ID/EX this cycle
- IFIDFlush_o  out  1  clear the IF/ID instruction to NOP
- state_o  out  2  00 RUN, 01 LDUSE, 10 FREEZE
- stall_cnt_o  out  16  count of cycles with PCWrite_o=0
- flush_cnt_o  out  16  count of cycles with IFIDFlush_o=1

Function
REQ-003 load_use SHALL be: IDEX_MemRead_i=1, IDEX_Rt_i!=0, and IDEX_Rt_i equals IFID_Rs_i or IFID_Rt_i.
REQ-004 PCWrite_o and IFIDWrite_o SHALL each be NOT(dmem_stall_i OR load_use); they are combinational and take effect in the same cycle.
REQ-005 IDEXWrite_o SHALL be NOT dmem_stall_i.
REQ-006 bubble_o SHALL be load_use AND NOT dmem_stall_i.
REQ-007 IFIDFlush_o SHALL be NOT dmem_stall_i AND NOT load_use AND (branch_taken_i OR flush_pend).
REQ-008 Priority SHALL be freeze > load-use bubble > flush.
- A taken branch coincident with load_use is not flushed; it is re-evaluated in ID next cycle.
REQ-009 flush_pend SHALL set at a clock edge where branch_taken_i=1 and dmem_stall_i=1.
- It SHALL clear at the edge ending any cycle with IFIDFlush_o=1.
- If both the set and clear conditions apply at the same edge, set wins.
REQ-010 The state register SHALL update every rising edge:
- next = FREEZE if dmem_stall_i
- else LDUSE if load_use
- else RUN
- Transitions SHALL be legal from any state to any state.
REQ-011 stall_cnt_o SHALL increment by 1 at each edge ending a cycle with PCWrite_o=0, saturating at 16'hFFFF.
REQ-012 flush_cnt_o SHALL increment by 1 at each edge ending a cycle with IFIDFlush_o=1, saturating at 16'hFFFF.
REQ-013 clear_i=1 SHALL zero both counters at the next edge.
- clear_i SHALL take priority over any increment at that edge.
- clear_i SHALL NOT affect state or flush_pend.
REQ-014 Encoding 11 of state_o SHALL be unreachable; if entered, next state SHALL follow REQ-010.

Reset
REQ-015 While rst_i=0, outputs SHALL be:
- state_o=00, flush_pend=0, stall_cnt_o=0, flush_cnt_o=0
- PCWrite_o=0, IFIDWrite_o=0, IDEXWrite_o=0, bubble_o=0, IFIDFlush_o=0
REQ-016 Assertion of rst_i SHALL take effect immediately, independent of clk_i, including mid-freeze or with a flush pending.
REQ-017 After rst_i deasserts, the first rising edge SHALL evaluate REQ-003..REQ-013 normally.

Verification
REQ-018 Load-use: IDEX_MemRead_i=1, IDEX_Rt_i=5, IFID_Rs_i=5 -> same cycle PCWrite_o=0, IFIDWrite_o=0, bubble_o=1; next cycle state_o=01, stall_cnt_o=1.
REQ-019 Load to $0: IDEX_Rt_i=0, IFID_Rt_i=0, IDEX_MemRead_i=1 -> PCWrite_o=1, bubble_o=0, state_o stays 00.
REQ-020 Flush during freeze:
- branch_taken_i=1 for 1 cycle with dmem_stall_i=1 held 3 cycles -> IFIDFlush_o=0 throughout the freeze.
- IFIDFlush_o=1 in the first cycle after dmem_stall_i falls, even with branch_taken_i=0.
- flush_cnt_o=1 and stall_cnt_o=3 afterwards.
REQ-021 Simultaneous events: load_use=1, branch_taken_i=1, dmem_stall_i=0 -> bubble_o=1, IFIDFlush_o=0; dmem_stall_i=1 added -> bubble_o=0, IDEXWrite_o=0, state_o=10 next.
REQ-022 Saturation/clear:
- hold dmem_stall_i=1 for 65537 cycles -> stall_cnt_o=16'hFFFF.
- clear_i=1 for one cycle while still stalled -> stall_cnt_o=0 at the next edge.
REQ-023 Async reset: drop rst_i mid-clock while state_o=10 and flush_pend=1 -> all outputs at REQ-015 values before the next edge; no flush occurs after release.
